pwm_step_gen: RTL and testbench

Step-driven PWM generator that sits directly downstream of the frequency dividers and consumes their divided output. The divided signal is sampled in the system clock domain. Each rising edge advances the PWM counter by one step, so the PWM period is (period+1) divided-clock cycles. Period and duty are loaded through a valid/ready handshake and take effect only at period boundaries, so the output waveform is always glitch-free.

---
 rtl/pwm_step_gen_if.sv | 23 ++
 rtl/pwm_step_gen.sv | 112 +++++++++++
 tb/tb_pwm_step_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_step_gen_if.sv
// rtl/pwm_step_gen_if.sv - config handshake bundle for pwm_step_gen
interface pwm_step_gen_if #(
  parameter int WIDTH = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic [WIDTH-1:0] cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_step_gen.sv
// rtl/pwm_step_gen.sv - step-driven PWM generator with boundary-synchronous config load
module pwm_step_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  pwm_step_gen_if.slave    cfg,
  output logic             pwm_out,
  output logic             period_done,
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_period_q, pend_period_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic [WIDTH-1:0] act_period_q, act_period_d;
  logic [WIDTH-1:0] act_duty_q, act_duty_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             period_done_q, period_done_d;

  logic step;
  logic accept;

  assign step   = tick_in & ~tick_q & en;
  assign accept = cfg.cfg_valid & ~pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tick_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      act_period_q  <= '0;
      act_duty_q    <= '0;
      cnt_q         <= '0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      pend_q        <= pend_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      act_period_q  <= act_period_d;
      act_duty_q    <= act_duty_d;
      cnt_q         <= cnt_d;
      period_done_q <= period_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_in;
    pend_d        = pend_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    act_period_d  = act_period_q;
    act_duty_d    = act_duty_q;
    cnt_d         = cnt_q;
    period_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pend_q) begin
          act_period_d = pend_period_q;
          act_duty_d   = pend_duty_q;
          pend_d       = 1'b0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (step) begin
          if (cnt_q == act_period_q) begin
            cnt_d         = '0;
            period_done_d = 1'b1;
            if (pend_q) begin
              act_period_d = pend_period_q;
              act_duty_d   = pend_duty_q;
              pend_d       = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept only fires when no config is pending, so it never races a load.
    if (accept) begin
      pend_d        = 1'b1;
      pend_period_d = cfg.cfg_period;
      pend_duty_d   = cfg.cfg_duty;
    end
  end

  assign cfg.cfg_ready = ~pend_q;
  assign pwm_out       = (state_q == ST_RUN) && (cnt_q < act_duty_q);
  assign period_done   = period_done_q;
  assign cnt           = cnt_q;

endmodule

// File: tb/tb_pwm_step_gen.sv
// tb/tb_pwm_step_gen.sv - randomized and directed checks of pwm_step_gen against a queue-based model
module tb_pwm_step_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       tick_in;
  logic       pwm_out;
  logic       period_done;
  logic [7:0] cnt;

  pwm_step_gen_if #(.WIDTH(8)) bus ();

  pwm_step_gen #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .tick_in     (tick_in),
    .cfg         (bus),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .cnt         (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int p;
    int d;
  } cfg_t;

  bit   m_run;
  int   m_cnt;
  int   m_ap;
  int   m_ad;
  bit   m_tq;
  bit   m_done;
  cfg_t m_pq[$];

  int div = 4;
  int ph  = 0;

  function automatic bit next_tick();
    ph = (ph + 1) % div;
    return ph < div / 2;
  endfunction

  task automatic model_reset();
    m_run  = 0;
    m_cnt  = 0;
    m_ap   = 0;
    m_ad   = 0;
    m_tq   = 0;
    m_done = 0;
    m_pq.delete();
  endtask

  task automatic model_load();
    cfg_t c;
    c = m_pq.pop_front();
    m_ap = c.p;
    m_ad = c.d;
  endtask

  task automatic model_step(input bit t, input bit e, input bit v, input int p, input int d);
    bit slot_free;
    slot_free = (m_pq.size() == 0);
    m_done = 0;
    if (!m_run) begin
      m_cnt = 0;
      if (m_pq.size() > 0) begin
        model_load();
        m_run = 1;
      end
    end else if (t && !m_tq && e) begin
      m_cnt = (m_cnt + 1) % (m_ap + 1);
      if (m_cnt == 0) begin
        m_done = 1;
        if (m_pq.size() > 0) model_load();
      end
    end
    if (v && slot_free) m_pq.push_back('{p, d});
    m_tq = t;
  endtask

  // One clk: drive after negedge, model at posedge, compare at next negedge.
  task automatic cycle(input bit e, input bit v, input int p, input int d);
    bit t;
    t = next_tick();
    tick_in        = t;
    en             = e;
    bus.cfg_valid  = v;
    bus.cfg_period = 8'(p);
    bus.cfg_duty   = 8'(d);
    @(posedge clk);
    model_step(t, e, v, p, d);
    @(negedge clk);
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("pwm_out", 32'(pwm_out), 32'(m_run && (m_cnt < m_ad)));
    chk("period_done", 32'(period_done), 32'(m_done));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_pq.size() == 0));
  endtask

  // Asserted between edges; outputs must clear without waiting for clk.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pwm_out", 32'(pwm_out), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_period_done", 32'(period_done), 0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
    bus.cfg_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_cnt(input int target, input bit v, input int p, input int d);
    int n;
    n = 0;
    while (m_cnt != target && n < 200) begin
      cycle(1'b1, v, p, d);
      n++;
    end
    if (m_cnt != target) chk("wait_cnt", 32'(m_cnt), 32'(target));
  endtask

  task automatic run_wave(input int p, input int d);
    int last;
    int highs;
    int exp_high;
    int pulses;
    div = 4;
    ph  = 0;
    async_reset();
    cycle(1'b1, 1'b1, p, d);
    last     = -1;
    highs    = 0;
    pulses   = 0;
    exp_high = ((d < p + 1) ? d : p + 1) * 4;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b0, 0, 0);
      highs += pwm_out;
      if (period_done) begin
        if (last >= 0) begin
          chk("period_clks", 32'(i - last), 32'(4 * (p + 1)));
          chk("high_clks", 32'(highs), 32'(exp_high));
        end
        pulses++;
        last  = i;
        highs = 0;
      end
    end
    if (pulses < 3) chk("period_pulses", 32'(pulses), 3);
  endtask

  initial begin
    rst            = 1'b1;
    en             = 1'b0;
    tick_in        = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_duty   = '0;
    model_reset();
    #1;
    chk("reset_pwm_out", 32'(pwm_out), 0);
    chk("reset_cnt", 32'(cnt), 0);
    chk("reset_period_done", 32'(period_done), 0);
    chk("reset_cfg_ready", 32'(bus.cfg_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    run_wave(3, 1);
    run_wave(3, 0);
    run_wave(3, 4);

    // Mid-period reconfiguration followed by a held second offer.
    run_wave(3, 1);
    run_to_cnt(1, 1'b0, 0, 0);
    cycle(1'b1, 1'b1, 7, 4);
    chk("mid_cfg_ready", 32'(bus.cfg_ready), 0);
    run_to_cnt(0, 1'b1, 2, 2);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 2, 2);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 0, 0);

    // Enable gating at cnt=2.
    run_to_cnt(2, 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 0, 0);
    chk("en_hold_cnt", 32'(cnt), 2);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 0, 0);

    // Reset mid-run with a config pending.
    run_to_cnt(2, 1'b0, 0, 0);
    cycle(1'b1, 1'b1, 5, 3);
    chk("pend_before_rst", 32'(bus.cfg_ready), 0);
    async_reset();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 0, 0);
    chk("idle_after_rst", 32'(pwm_out), 0);

    for (int i = 0; i < 2500; i++) begin
      int p;
      int d;
      if ($urandom % 200 == 0) div = $urandom_range(2, 6);
      p = ($urandom % 8 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      d = $urandom_range(0, p + 2);
      if (d > 255) d = 255;
      if ($urandom % 700 == 0) async_reset();
      cycle($urandom % 10 != 0, $urandom % 5 == 0, p, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
